// File: rtl/fetch_pipe_ctrl_pkg.sv
// Shared types and constants for the front-end fetch sequencer.
// Covers the state encoding, the reset and chip-enable levels, and the bundle
// of combinational pipeline control strobes.
`timescale 1ns/1ps

package fetch_pipe_ctrl_pkg;

    // Two-bit sequencer state encoding (FPC_IDLE / FETCH / WAIT / REDIR)
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_REDIR = 2'd3
    } fpc_state_e;

    // Reset and chip-enable levels shared with the rest of the core
    localparam logic RST_ENABLE   = 1'b0;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    // Per-cycle hold/flush/load strobes towards pc, if_id and id_ex
    typedef struct packed {
        logic pc_hold;
        logic pc_load;
        logic if_id_hold;
        logic if_id_flush;
        logic id_ex_hold;
        logic id_ex_flush;
    } fpc_ctrl_t;

    localparam fpc_ctrl_t CTRL_NONE = '{default: 1'b0};

endpackage : fetch_pipe_ctrl_pkg

// File: rtl/fetch_pipe_ctrl.sv
// Front-end sequencer. Drives the pc (hold/load), the instruction memory chip
// enable, and the hold/flush strobes of if_id and id_ex.
//
// Requests are taken in this order: EX multicycle stall, then taken branch,
// then ID load-use stall, then instruction-memory wait.
//
// If a branch resolves while a fetch is still outstanding, the target is
// parked in tgt_q. The stale fetch response is discarded when it arrives, and
// the pc is then loaded with the parked target.
//
// Optional feature: define FETCH_STALL_CNT_EN to get a saturating count of the
// cycles with pc_hold=1. Without the macro, stall_cnt is tied to zero.
`timescale 1ns/1ps

module fetch_pipe_ctrl
    import fetch_pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              sys_clk,
    input  logic              rstn,
    input  logic              imem_ready,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              ce,
    output logic              pc_hold,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              if_id_hold,
    output logic              if_id_flush,
    output logic              id_ex_hold,
    output logic              id_ex_flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    fpc_state_e        state_q;
    fpc_state_e        state_d;
    logic              ce_q;
    logic              ce_d;
    logic [ADDR_W-1:0] tgt_q;
    logic [ADDR_W-1:0] tgt_d;
    logic [ADDR_W-1:0] pc_target_d;
    fpc_ctrl_t         ctrl_d;

    // Next-state, parked-target and same-cycle control strobe decode
    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        ce_d        = ce_q;
        ctrl_d      = CTRL_NONE;
        // Shows the parked target whenever no load is requested
        pc_target_d = tgt_q;

        case (state_q)
            S_IDLE: begin
                // Leave idle on the first clock after reset.
                // The first fetch is issued one cycle later.
                ce_d    = CHIP_ENABLE;
                state_d = S_FETCH;
            end

            S_FETCH, S_WAIT: begin
                if (stallreq_ex) begin
                    // EX has not retired, so a branch it flags is not final yet
                    ctrl_d.pc_hold    = 1'b1;
                    ctrl_d.if_id_hold = 1'b1;
                    ctrl_d.id_ex_hold = 1'b1;
                end else if (branch_flag && (imem_ready || (state_q == S_FETCH))) begin
                    // No fetch is pending that could overwrite the redirect
                    ctrl_d.pc_load     = 1'b1;
                    pc_target_d        = branch_target;
                    ctrl_d.if_id_flush = 1'b1;
                    ctrl_d.id_ex_flush = 1'b1;
                    state_d            = S_FETCH;
                end else if (branch_flag) begin
                    // A fetch is still outstanding.
                    // Park the target and drop the response when it lands.
                    tgt_d              = branch_target;
                    ctrl_d.pc_hold     = 1'b1;
                    ctrl_d.if_id_flush = 1'b1;
                    ctrl_d.id_ex_flush = 1'b1;
                    state_d            = S_REDIR;
                end else if (stallreq_id) begin
                    // Load-use: freeze fetch and decode, and send a bubble into EX
                    ctrl_d.pc_hold     = 1'b1;
                    ctrl_d.if_id_hold  = 1'b1;
                    ctrl_d.id_ex_flush = 1'b1;
                end else if (!imem_ready) begin
                    // Memory wait: hold the pc and let a NOP into decode
                    ctrl_d.pc_hold     = 1'b1;
                    ctrl_d.if_id_flush = 1'b1;
                    state_d            = S_WAIT;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_REDIR: begin
                // Keep the pipe empty until the stale response has gone by
                ctrl_d.pc_hold     = 1'b1;
                ctrl_d.if_id_flush = 1'b1;
                ctrl_d.id_ex_flush = 1'b1;
                // Flush dominates hold downstream; hold is only a hint to EX
                ctrl_d.id_ex_hold  = stallreq_ex;
                if (branch_flag) begin
                    // A newer redirect replaces the parked one
                    tgt_d = branch_target;
                end
                if (imem_ready) begin
                    ctrl_d.pc_hold = 1'b0;
                    ctrl_d.pc_load = 1'b1;
                    pc_target_d    = branch_flag ? branch_target : tgt_q;
                    state_d        = S_FETCH;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, chip enable and parked redirect target
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (rstn == RST_ENABLE) begin
            state_q <= S_IDLE;
            ce_q    <= CHIP_DISABLE;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            ce_q    <= ce_d;
            tgt_q   <= tgt_d;
        end
    end

    assign ce          = ce_q;
    assign pc_hold     = ctrl_d.pc_hold;
    assign pc_load     = ctrl_d.pc_load;
    assign pc_target   = pc_target_d;
    assign if_id_hold  = ctrl_d.if_id_hold;
    assign if_id_flush = ctrl_d.if_id_flush;
    assign id_ex_hold  = ctrl_d.id_ex_hold;
    assign id_ex_flush = ctrl_d.id_ex_flush;

`ifdef FETCH_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    // Saturating count of held fetch cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ctrl_d.pc_hold && (state_q != S_IDLE) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (rstn == RST_ENABLE) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

    // Structural invariants of the control strobes
    a_pc_exclusive : assert property (@(posedge sys_clk) disable iff (!rstn)
        !(pc_hold && pc_load));
    a_if_id_exclusive : assert property (@(posedge sys_clk) disable iff (!rstn)
        !(if_id_hold && if_id_flush));
    a_id_ex_exclusive : assert property (@(posedge sys_clk) disable iff (!rstn)
        !(id_ex_hold && id_ex_flush) || (state_q == S_REDIR));
    a_target_parked : assert property (@(posedge sys_clk) disable iff (!rstn)
        pc_load || (pc_target == tgt_q));

endmodule : fetch_pipe_ctrl
